// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch comparator / predictor.
package branch_pkg;

  // Branch condition select codes.
  typedef enum logic [2:0] {
    B_BEQ    = 3'd0,
    B_BGEZAL = 3'd1,
    B_BNE    = 3'd2,
    B_BGEZ   = 3'd3,
    B_BLTZ   = 3'd4,
    B_BLEZ   = 3'd5,
    B_BGTZ   = 3'd6,
    B_BLTZAL = 3'd7
  } b_sel_e;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt_e;

  localparam cnt_e CNT_RESET = CNT_WNT;

  // Saturating counter step towards the resolved direction.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic tkn);
    logic [1:0] res;
    res = cnt;
    if (tkn) begin
      if (cnt != CNT_ST) res = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode on forwarded operands (purely combinational).
module branch_cond
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       b_sel,
  output logic             cond
);

  logic a_neg;
  logic a_zero;
  logic a_eq_b;

  assign a_neg  = op_a[WIDTH-1];
  assign a_zero = (op_a == '0);
  assign a_eq_b = (op_a == op_b);

  // Select the condition; op_b only matters for beq/bne.
  always_comb begin
    cond = 1'b0;
    case (b_sel)
      B_BEQ:    cond = a_eq_b;
      B_BGEZAL: cond = ~a_neg;
      B_BNE:    cond = ~a_eq_b;
      B_BGEZ:   cond = ~a_neg;
      B_BLTZ:   cond = a_neg;
      B_BLEZ:   cond = a_neg | a_zero;
      B_BGTZ:   cond = ~a_neg & ~a_zero;
      B_BLTZAL: cond = a_neg;
      default:  cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_cmp.sv
// ID-stage branch comparator with a PC-indexed BHT of 2-bit counters.
// Optional statistics counters are built when BRANCH_STATS_EN is defined;
// otherwise br_count/mp_count are tied to zero.
module branch_predict_cmp
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BHT_IDX = 6,
  parameter int unsigned PC_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             id_pred_taken,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       b_sel,
  output logic             taken,
  output logic             is_link,
  output logic             mispredict,
  output logic [31:0]      br_count,
  output logic [31:0]      mp_count
);

  localparam int unsigned ENTRIES = 1 << BHT_IDX;

  logic [BHT_IDX-1:0] if_idx;
  logic [BHT_IDX-1:0] id_idx;
  logic               cond;
  logic               upd;
  logic               unused_pc;

  logic [1:0] bht_q [ENTRIES];
  logic [1:0] bht_d [ENTRIES];

  assign if_idx    = if_pc[BHT_IDX+1:2];
  assign id_idx    = id_pc[BHT_IDX+1:2];
  assign unused_pc = ^{if_pc, id_pc};

  branch_cond #(
    .WIDTH(WIDTH)
  ) u_cond (
    .op_a (op_a),
    .op_b (op_b),
    .b_sel(b_sel),
    .cond (cond)
  );

  // Resolution outputs and training qualifier.
  always_comb begin
    upd        = id_valid & ~id_stall;
    taken      = id_valid & cond;
    is_link    = id_valid & ((b_sel == B_BGEZAL) | (b_sel == B_BLTZAL));
    mispredict = upd & (taken ^ id_pred_taken);
  end

  // IF lookup reads the registered table: no same-cycle bypass.
  assign pred_taken = bht_q[if_idx][1];

  // Next table contents: only the resolving entry moves.
  always_comb begin
    bht_d = bht_q;
    if (upd) bht_d[id_idx] = cnt_next(bht_q[id_idx], taken);
  end

  // Table storage; reset forces every entry to weakly-not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_RESET;
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mp_count_q, mp_count_d;

  // Wrap-around event counters.
  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (upd)        br_count_d = br_count_q + 32'd1;
    if (mispredict) mp_count_d = mp_count_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;
`else
  assign br_count = '0;
  assign mp_count = '0;
`endif

endmodule

// File: doc/branch_predict_cmp.md
Name: branch_predict_cmp

Overview:
- Parametrised successor to the ID-stage branch comparator. Evaluates all branch conditions on forwarded operands.
- Adds a BHT of 2-bit saturating counters, indexed by PC, giving an IF-stage taken/not-taken prediction.
- Flags mispredicts in ID and trains the table on every resolved branch.
- Sits between the IF PC mux (prediction) and the ID hazard/flush logic (resolution).

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- BHT_IDX, 6, log2 of BHT entries; table has 2**BHT_IDX entries, indexed by pc[BHT_IDX+1:2].
- PC_W, 32, PC width (>= BHT_IDX+2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_pc  in  PC_W  IF-stage PC for lookup.
- pred_taken  out  1  prediction for if_pc.
- id_valid  in  1  ID holds a branch instruction.
- id_stall  in  1  ID stalled by the hazard unit; suppresses training.
- id_pc  in  PC_W  PC of the branch in ID.
- id_pred_taken  in  1  prediction carried down from IF with the branch.
- op_a  in  WIDTH  forwarded rs value.
- op_b  in  WIDTH  forwarded rt value.
- b_sel  in  3  condition select.
- taken  out  1  resolved condition.
- is_link  out  1  branch writes $31.
- mispredict  out  1  flush request.
- br_count  out  32  resolved branches (optional feature).
- mp_count  out  32  mispredicts (optional feature).

Behaviour:
- b_sel encoding (compatible with previous block):
  - 0 beq: a==b
  - 1 bgezal: a[W-1]==0
  - 2 bne: a!=b
  - 3 bgez: a[W-1]==0
  - 4 bltz: a[W-1]==1
  - 5 blez: a[W-1]==1 or a==0
  - 6 bgtz: a[W-1]==0 and a!=0
  - 7 bltzal: a[W-1]==1
- taken: combinational. Equals the condition when id_valid=1; 0 when id_valid=0. op_b is ignored for codes 1 and 3-7.
- is_link: id_valid & (b_sel==1 | b_sel==7). Independent of taken.
- mispredict: combinational, id_valid & ~id_stall & (taken ^ id_pred_taken). Never asserted while stalled.
- pred_taken: combinational read, bit 1 of counter[if_pc[BHT_IDX+1:2]].
- Counter states: 0 SNT, 1 WNT, 2 WT, 3 ST.
- Update occurs at posedge clk when id_valid & ~id_stall:
  - taken=1: counter increments, saturating at 3.
  - taken=0: counter decrements, saturating at 0.
  - Exactly one entry changes per cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (no bypass). The new value is visible the following cycle.
- Aliasing: distinct PCs sharing an index share a counter; no tags.
- Reset (reset=0): every counter goes to WNT (1) immediately and asynchronously, so pred_taken=0.
  - Optional counters go to 0.
  - Reset asserted mid-operation discards any pending update.
  - taken, is_link and mispredict follow their inputs during reset.
- X-free: all outputs are defined from reset onward, including when id_valid=0.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - br_count increments on each id_valid & ~id_stall cycle.
  - mp_count increments on each mispredict cycle.
  - Both are 32-bit wrap-around counters (0xFFFFFFFF to 0); they reset to 0 asynchronously.
- Undefined: both ports are present and tied to 0; no counter registers are synthesised.

Decomposition:
- branch_pkg holds:
  - B_BEQ..B_BLTZAL b_sel constants (0-7).
  - CNT_SNT/WNT/WT/ST 2-bit state constants.
  - CNT_RESET = CNT_WNT.
- Sub-module branch_cond: purely combinational, parameterised by WIDTH; inputs op_a, op_b, b_sel; output cond. Keeps the condition decode separately testable.
- BHT storage and counter update stay in branch_predict_cmp.

Test Plan:
- Reset release, if_pc=0x3000 -> pred_taken=0. Every index reads 1 (probe 0x3000 through 0x30FC with BHT_IDX=6).
- Condition sweep:
  - b_sel=5, op_a=0 -> taken=1.
  - b_sel=6, op_a=0 -> taken=0.
  - b_sel=6, op_a=0x00000001 -> taken=1.
  - b_sel=7, op_a=0x80000000 -> taken=1, is_link=1.
  - b_sel=0, a=b=0x1234 -> taken=1.
  - b_sel=2, same operands -> taken=0.
- Training, id_pc=0x3010, bgez with op_a=5, id_pred_taken=0:
  - Cycle 1: mispredict=1.
  - Cycle 2, with if_pc=0x3010 -> pred_taken=1.
  - Two further taken resolutions saturate the counter at 3.
  - Three not-taken resolutions then give pred_taken=0.
- Stall: id_valid=1, id_stall=1, mismatched prediction for 4 cycles -> mispredict=0, counter unchanged, br_count unchanged.
- Collision: update of index for 0x3020 while if_pc=0x3020 in the same cycle -> pred_taken shows the old value that cycle and the new value the next.
- Reset mid-run after 5 branches/2 mispredicts (BRANCH_STATS_EN defined):
  - Before reset: br_count=5, mp_count=2.
  - Assert reset asynchronously, mid-cycle -> counts=0 and all BHT entries=1 before the next edge.
